// File: rtl/fwd_pkg.sv
// fwd_pkg
// Shared constants for the forwarding / load-use hazard unit.
//   - FWD_*  : 2-bit operand-select codes driven on fwd_a / fwd_b
//   - state_e: hazard FSM state encoding (IDLE, HOLD)
package fwd_pkg;

  localparam logic [1:0] FWD_REG = 2'd0;  // operand from register file
  localparam logic [1:0] FWD_MEM = 2'd1;  // operand from MEM-stage result
  localparam logic [1:0] FWD_EX  = 2'd2;  // operand from EX/ALU result
  localparam logic [1:0] FWD_WB  = 2'd3;  // operand from WB result

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_e;

endpackage

// File: rtl/fwd_operand_sel.sv
// fwd_operand_sel
// Compares one decode-stage source register against the EX, MEM and WB
// destinations and priority-encodes the operand select (EX > MEM > WB).
// Ports:
//   src_i, src_used_i            decode source register and its read-enable
//   ex_rd_i, ex_reg_write_i      EX destination / write-enable
//   mem_rd_i, mem_reg_write_i    MEM destination / write-enable
//   wb_rd_i, wb_reg_write_i      WB destination / write-enable
//   sel_o                        2-bit select (fwd_pkg FWD_* codes)
//   ex_match_o                   EX stage supplies this operand (used for load-use)
module fwd_operand_sel
  import fwd_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] src_i,
  input  logic              src_used_i,
  input  logic [REG_AW-1:0] ex_rd_i,
  input  logic              ex_reg_write_i,
  input  logic [REG_AW-1:0] mem_rd_i,
  input  logic              mem_reg_write_i,
  input  logic [REG_AW-1:0] wb_rd_i,
  input  logic              wb_reg_write_i,
  output logic [1:0]        sel_o,
  output logic              ex_match_o
);

  logic ex_hit;
  logic mem_hit;
  logic wb_hit;

  // Register 0 is hard-wired to zero, so a zero destination never matches.
  assign ex_hit  = ex_reg_write_i  && (ex_rd_i  != {REG_AW{1'b0}}) && (ex_rd_i  == src_i) && src_used_i;
  assign mem_hit = mem_reg_write_i && (mem_rd_i != {REG_AW{1'b0}}) && (mem_rd_i == src_i) && src_used_i;
  assign wb_hit  = wb_reg_write_i  && (wb_rd_i  != {REG_AW{1'b0}}) && (wb_rd_i  == src_i) && src_used_i;

  assign ex_match_o = ex_hit;

  // Youngest producer wins: EX, then MEM, then WB, else register file.
  always_comb begin
    sel_o = FWD_REG;
    if (ex_hit) begin
      sel_o = FWD_EX;
    end else if (mem_hit) begin
      sel_o = FWD_MEM;
    end else if (wb_hit) begin
      sel_o = FWD_WB;
    end else begin
      sel_o = FWD_REG;
    end
  end

endmodule

// File: rtl/forward_hazard_unit.sv
// forward_hazard_unit
// Operand-forwarding and load-use hazard controller for a 5-stage MIPS
// pipeline, placed at the ID/EX boundary.
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   dec_rs, dec_rt (+ _used)         decode-stage sources and read-enables
//   ex_rd, ex_reg_write, ex_mem_read EX destination, write-enable, load flag
//   mem_rd, mem_reg_write            MEM destination / write-enable
//   wb_rd, wb_reg_write              WB destination / write-enable
//   fwd_a, fwd_b                     operand selects (combinational)
//   stall, bubble_ex                 freeze PC+IF/ID, NOP into ID/EX (identical)
//   stall_cnt, fwd_cnt               saturating performance counters
// Build option: define FWD_PERF_CNT_EN to compile in the performance
// counters; otherwise stall_cnt and fwd_cnt are tied to zero.
module forward_hazard_unit
  import fwd_pkg::*;
#(
  parameter int REG_AW   = 5,
  parameter int LOAD_LAT = 1,
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] dec_rs,
  input  logic [REG_AW-1:0] dec_rt,
  input  logic              dec_rs_used,
  input  logic              dec_rt_used,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_reg_write,
  input  logic              ex_mem_read,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic              mem_reg_write,
  input  logic              wb_reg_write,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic              stall,
  output logic              bubble_ex,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  fwd_cnt
);

  // The first stall cycle is spent in IDLE; HOLD covers the remaining
  // LOAD_LAT-1 cycles, with hold_cnt reaching 0 on the last one.
  localparam bit         MULTI_CYCLE = (LOAD_LAT > 1);
  localparam logic [1:0] HOLD_INIT   = MULTI_CYCLE ? 2'(LOAD_LAT - 2) : 2'd0;

  logic [1:0] sel_a;
  logic [1:0] sel_b;
  logic       ex_match_a;
  logic       ex_match_b;
  logic       load_use_haz;
  logic       stall_raw;
  state_e     state_q;
  state_e     state_d;
  logic [1:0] hold_cnt_q;
  logic [1:0] hold_cnt_d;

  fwd_operand_sel #(.REG_AW(REG_AW)) u_sel_a (
    .src_i           (dec_rs),
    .src_used_i      (dec_rs_used),
    .ex_rd_i         (ex_rd),
    .ex_reg_write_i  (ex_reg_write),
    .mem_rd_i        (mem_rd),
    .mem_reg_write_i (mem_reg_write),
    .wb_rd_i         (wb_rd),
    .wb_reg_write_i  (wb_reg_write),
    .sel_o           (sel_a),
    .ex_match_o      (ex_match_a)
  );

  fwd_operand_sel #(.REG_AW(REG_AW)) u_sel_b (
    .src_i           (dec_rt),
    .src_used_i      (dec_rt_used),
    .ex_rd_i         (ex_rd),
    .ex_reg_write_i  (ex_reg_write),
    .mem_rd_i        (mem_rd),
    .mem_reg_write_i (mem_reg_write),
    .wb_rd_i         (wb_rd),
    .wb_reg_write_i  (wb_reg_write),
    .sel_o           (sel_b),
    .ex_match_o      (ex_match_b)
  );

  // Both operands hitting the same load still form a single hazard.
  assign load_use_haz = ex_mem_read && (ex_match_a || ex_match_b);

  // Hazard FSM state and hold down-counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      hold_cnt_q <= 2'd0;
    end else begin
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
    end
  end

  // Hazard FSM next-state and raw stall request.
  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    stall_raw  = 1'b0;
    case (state_q)
      IDLE: begin
        stall_raw = load_use_haz;
        if (load_use_haz && MULTI_CYCLE) begin
          state_d    = HOLD;
          hold_cnt_d = HOLD_INIT;
        end else begin
          state_d    = IDLE;
        end
      end
      HOLD: begin
        // Inputs are ignored here; the hazard is re-checked back in IDLE.
        stall_raw = 1'b1;
        if (hold_cnt_q == 2'd0) begin
          state_d = IDLE;
        end else begin
          hold_cnt_d = hold_cnt_q - 2'd1;
        end
      end
      default: begin
        state_d    = IDLE;
        hold_cnt_d = 2'd0;
      end
    endcase
  end

  // Reset overrides the outputs in the same cycle, including mid-HOLD.
  assign stall     = rst ? 1'b0 : stall_raw;
  assign bubble_ex = stall;
  assign fwd_a     = rst ? FWD_REG : sel_a;
  assign fwd_b     = rst ? FWD_REG : sel_b;

`ifdef FWD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] fwd_cnt_q;

  // Saturating stall-cycle and forwarding-cycle counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= {CNT_W{1'b0}};
      fwd_cnt_q   <= {CNT_W{1'b0}};
    end else begin
      if (stall && (stall_cnt_q != {CNT_W{1'b1}})) begin
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      end
      // One count per cycle regardless of how many operands forward.
      if (((fwd_a != FWD_REG) || (fwd_b != FWD_REG)) && (fwd_cnt_q != {CNT_W{1'b1}})) begin
        fwd_cnt_q <= fwd_cnt_q + CNT_W'(1);
      end
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign fwd_cnt   = fwd_cnt_q;
`else
  assign stall_cnt = {CNT_W{1'b0}};
  assign fwd_cnt   = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_forward_hazard_unit.sv
// tb_forward_hazard_unit
// Drives two instances of forward_hazard_unit from shared inputs:
//   u_lat1: LOAD_LAT=1, CNT_W=16
//   u_lat3: LOAD_LAT=3, CNT_W=2 (exercises counter saturation)
// Expected values come from a cycle-level reference model that tracks the
// number of stall cycles still owed per instance and plain saturating counts.
module tb_forward_hazard_unit;

  localparam int AW = 5;

`ifdef FWD_PERF_CNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] dec_rs, dec_rt, ex_rd, mem_rd, wb_rd;
  logic          dec_rs_used, dec_rt_used, ex_reg_write, ex_mem_read;
  logic          mem_reg_write, wb_reg_write;

  logic [1:0]  fwd_a1, fwd_b1, fwd_a3, fwd_b3;
  logic        stall1, bubble1, stall3, bubble3;
  logic [15:0] scnt1, fcnt1;
  logic [1:0]  scnt3, fcnt3;

  int n_cmp;
  int n_bad;

  // reference model state
  int rem1, rem3;          // stall cycles still owed after the current one
  int sc1, fc1, sc3, fc3;  // expected counter values

  always #5 clk = ~clk;

  forward_hazard_unit #(.REG_AW(AW), .LOAD_LAT(1), .CNT_W(16)) u_lat1 (
    .clk(clk), .rst(rst), .dec_rs(dec_rs), .dec_rt(dec_rt),
    .dec_rs_used(dec_rs_used), .dec_rt_used(dec_rt_used),
    .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .mem_rd(mem_rd), .wb_rd(wb_rd), .mem_reg_write(mem_reg_write),
    .wb_reg_write(wb_reg_write), .fwd_a(fwd_a1), .fwd_b(fwd_b1),
    .stall(stall1), .bubble_ex(bubble1), .stall_cnt(scnt1), .fwd_cnt(fcnt1)
  );

  forward_hazard_unit #(.REG_AW(AW), .LOAD_LAT(3), .CNT_W(2)) u_lat3 (
    .clk(clk), .rst(rst), .dec_rs(dec_rs), .dec_rt(dec_rt),
    .dec_rs_used(dec_rs_used), .dec_rt_used(dec_rt_used),
    .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .mem_rd(mem_rd), .wb_rd(wb_rd), .mem_reg_write(mem_reg_write),
    .wb_reg_write(wb_reg_write), .fwd_a(fwd_a3), .fwd_b(fwd_b3),
    .stall(stall3), .bubble_ex(bubble3), .stall_cnt(scnt3), .fwd_cnt(fcnt3)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // A stage supplies src when it writes a nonzero register equal to a used src.
  function automatic bit supplies(input logic wr, input logic [AW-1:0] rd,
                                  input logic [AW-1:0] src, input logic used);
    return wr && (rd != 0) && (rd == src) && used;
  endfunction

  // Pick the youngest producing stage: EX(2), then MEM(1), then WB(3), else 0.
  function automatic int ref_sel(input logic [AW-1:0] src, input logic used);
    logic [AW-1:0] rds [3];
    logic          wrs [3];
    int            code [3];
    rds[0] = ex_rd;  wrs[0] = ex_reg_write;  code[0] = 2;
    rds[1] = mem_rd; wrs[1] = mem_reg_write; code[1] = 1;
    rds[2] = wb_rd;  wrs[2] = wb_reg_write;  code[2] = 3;
    for (int k = 0; k < 3; k++) begin
      if (supplies(wrs[k], rds[k], src, used)) return code[k];
    end
    return 0;
  endfunction

  task automatic clear_inputs();
    dec_rs = '0; dec_rt = '0; dec_rs_used = 1'b0; dec_rt_used = 1'b0;
    ex_rd = '0; ex_reg_write = 1'b0; ex_mem_read = 1'b0;
    mem_rd = '0; mem_reg_write = 1'b0; wb_rd = '0; wb_reg_write = 1'b0;
  endtask

  // Check every output of both instances for the current cycle, then clock
  // and advance the reference model.
  task automatic step(input string tag);
    int ea, eb, s1, s3;
    bit haz;
    #2;
    haz = ex_mem_read && (supplies(ex_reg_write, ex_rd, dec_rs, dec_rs_used) ||
                          supplies(ex_reg_write, ex_rd, dec_rt, dec_rt_used));
    ea = rst ? 0 : ref_sel(dec_rs, dec_rs_used);
    eb = rst ? 0 : ref_sel(dec_rt, dec_rt_used);
    s1 = rst ? 0 : ((rem1 > 0 || haz) ? 1 : 0);
    s3 = rst ? 0 : ((rem3 > 0 || haz) ? 1 : 0);
    check({tag, ".fwd_a1"}, fwd_a1, ea);
    check({tag, ".fwd_b1"}, fwd_b1, eb);
    check({tag, ".fwd_a3"}, fwd_a3, ea);
    check({tag, ".fwd_b3"}, fwd_b3, eb);
    check({tag, ".stall1"}, stall1, s1);
    check({tag, ".bubble1"}, bubble1, s1);
    check({tag, ".stall3"}, stall3, s3);
    check({tag, ".bubble3"}, bubble3, s3);
    check({tag, ".scnt1"}, scnt1, CNT_ON ? sc1 : 0);
    check({tag, ".fcnt1"}, fcnt1, CNT_ON ? fc1 : 0);
    check({tag, ".scnt3"}, scnt3, CNT_ON ? sc3 : 0);
    check({tag, ".fcnt3"}, fcnt3, CNT_ON ? fc3 : 0);
    @(posedge clk);
    if (rst) begin
      rem1 = 0; rem3 = 0; sc1 = 0; fc1 = 0; sc3 = 0; fc3 = 0;
    end else begin
      if (rem1 > 0) rem1--; else if (haz) rem1 = 1 - 1;
      if (rem3 > 0) rem3--; else if (haz) rem3 = 3 - 1;
      if (s1 == 1 && sc1 < 65535) sc1++;
      if (s3 == 1 && sc3 < 3) sc3++;
      if ((ea != 0 || eb != 0) && fc1 < 65535) fc1++;
      if ((ea != 0 || eb != 0) && fc3 < 3) fc3++;
    end
    #1;
  endtask

  task automatic set_load_hazard();
    clear_inputs();
    ex_rd = 5'd7; ex_reg_write = 1'b1; ex_mem_read = 1'b1;
    dec_rt = 5'd7; dec_rt_used = 1'b1;
  endtask

  initial begin
    n_cmp = 0; n_bad = 0;
    rem1 = 0; rem3 = 0; sc1 = 0; fc1 = 0; sc3 = 0; fc3 = 0;

    // reset with a hazard and forwarding visible on the inputs
    rst = 1'b1;
    set_load_hazard();
    dec_rs = 5'd7; dec_rs_used = 1'b1;
    @(posedge clk); #1;
    #1;
    check("rst.stall3", stall3, 0);
    check("rst.fwd_a1", fwd_a1, 0);
    step("rst");
    rst = 1'b0;

    // EX and MEM forwarding to different operands
    clear_inputs();
    ex_rd = 5'd5; ex_reg_write = 1'b1; dec_rs = 5'd5; dec_rs_used = 1'b1;
    mem_rd = 5'd6; mem_reg_write = 1'b1; dec_rt = 5'd6; dec_rt_used = 1'b1;
    #1;
    check("tp1.fwd_a", fwd_a1, 2);
    check("tp1.fwd_b", fwd_b1, 1);
    check("tp1.stall", stall1, 0);
    step("tp1");

    // priority EX > MEM > WB on the same register
    clear_inputs();
    ex_rd = 5'd3; mem_rd = 5'd3; wb_rd = 5'd3;
    ex_reg_write = 1'b1; mem_reg_write = 1'b1; wb_reg_write = 1'b1;
    dec_rs = 5'd3; dec_rs_used = 1'b1;
    #1; check("tp2.ex", fwd_a1, 2); step("tp2a");
    ex_reg_write = 1'b0;
    #1; check("tp2.mem", fwd_a1, 1); step("tp2b");
    mem_reg_write = 1'b0;
    #1; check("tp2.wb", fwd_a1, 3); step("tp2c");

    // register 0 never forwards or stalls
    clear_inputs();
    ex_reg_write = 1'b1; mem_reg_write = 1'b1; wb_reg_write = 1'b1;
    ex_mem_read = 1'b1; dec_rs_used = 1'b1; dec_rt_used = 1'b1;
    #1;
    check("r0.fwd_a", fwd_a1, 0);
    check("r0.fwd_b", fwd_b1, 0);
    check("r0.stall", stall3, 0);
    step("r0");

    // unused operand does not stall
    set_load_hazard();
    dec_rt_used = 1'b0;
    #1; check("unused.stall1", stall1, 0); check("unused.stall3", stall3, 0);
    step("unused");

    // load-use: 1 cycle on LOAD_LAT=1, 3 cycles on LOAD_LAT=3
    dec_rt_used = 1'b1;
    #1; check("lu0.stall1", stall1, 1); check("lu0.bub1", bubble1, 1);
    step("lu0");
    clear_inputs();
    #1; check("lu1.stall1", stall1, 0); check("lu1.stall3", stall3, 1);
    step("lu1");
    #1; check("lu2.stall3", stall3, 1); step("lu2");
    #1; check("lu3.stall3", stall3, 0); step("lu3");

    // reset asserted during HOLD drops stall at once and for good
    set_load_hazard();
    step("rh0");
    clear_inputs();
    rst = 1'b1;
    #1; check("rh1.stall3", stall3, 0); step("rh1");
    rst = 1'b0;
    #1; check("rh2.stall3", stall3, 0); step("rh2");
    step("rh3");

    // counter saturation after 5 stall cycles, then clear by reset
    rst = 1'b1; step("cs_rst"); rst = 1'b0;
    set_load_hazard();
    for (int i = 0; i < 5; i++) step("cs_run");
    clear_inputs();
    #1;
    check("cs.scnt3", scnt3, CNT_ON ? 3 : 0);
    check("cs.scnt1", scnt1, CNT_ON ? 5 : 0);
    step("cs_end");
    rst = 1'b1; step("cs_clr"); rst = 1'b0;
    #1; check("cs.clr3", scnt3, 0); check("cs.clrf3", fcnt3, 0);
    step("cs_after");

    // randomized traffic on a small register range to provoke many matches
    for (int i = 0; i < 600; i++) begin
      rst           = ($urandom_range(0, 49) == 0);
      dec_rs        = AW'($urandom_range(0, 3));
      dec_rt        = AW'($urandom_range(0, 3));
      ex_rd         = AW'($urandom_range(0, 3));
      mem_rd        = AW'($urandom_range(0, 3));
      wb_rd         = AW'($urandom_range(0, 3));
      dec_rs_used   = 1'($urandom_range(0, 1));
      dec_rt_used   = 1'($urandom_range(0, 1));
      ex_reg_write  = 1'($urandom_range(0, 1));
      ex_mem_read   = 1'($urandom_range(0, 1));
      mem_reg_write = 1'($urandom_range(0, 1));
      wb_reg_write  = 1'($urandom_range(0, 1));
      step("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
